// File: rtl/laundry_pkg.sv
// rtl/laundry_pkg.sv - shared constants, machine-state encoding and clog2 helper for the laundry scheduler
package laundry_pkg;

  localparam int DEF_N_MACHINES  = 4;
  localparam int DEF_QUEUE_DEPTH = 4;

  // Occupancy encoding of one machine as seen by the scheduler.
  typedef enum logic {
    MACH_IDLE = 1'b0,
    MACH_BUSY = 1'b1
  } mach_state_e;

  // Smallest r with 2**r >= v (v >= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/laundry_bank_scheduler_fifo.sv
// rtl/laundry_bank_scheduler_fifo.sv - 1-bit-wide pending-request FIFO (module sched_fifo)
// Purpose: holds the double-wash option of each paid, not yet dispatched request.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i, din_i   write request and data; refused when full unless popping in the same cycle
//   pop_i           read request; ignored when empty
//   dout_o          head entry
//   full_o, empty_o occupancy flags
//   count_o         number of stored entries
module sched_fifo
  import laundry_pkg::*;
#(
  parameter  int DEPTH = DEF_QUEUE_DEPTH,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          din_i,
  input  logic          pop_i,
  output logic          dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is fine then.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/laundry_bank_scheduler.sv
// rtl/laundry_bank_scheduler.sv - queues paid wash requests and dispatches them round-robin to free machines
// Purpose: one coin acceptor shared by N_MACHINES machine controllers.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   coin_in_i                one-cycle pulse per paid request
//   double_wash_req_i        double-wash option, sampled with coin_in_i
//   sched_en_i               dispatch enable (queueing continues while low)
//   machine_done_i           wash_done level from each machine
//   machine_coin_o           one-cycle start pulse per machine
//   machine_double_wash_o    option held for the job running on each machine
//   busy_mask_o              1 = machine owned by a dispatched job
//   queue_count_o            pending requests
//   coin_reject_o            one-cycle pulse when a request is dropped on a full queue
//   jobs_done_o              wrapping completed-job counter
module laundry_bank_scheduler
  import laundry_pkg::*;
#(
  parameter  int N_MACHINES  = DEF_N_MACHINES,
  parameter  int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  parameter  int CNT_W       = 16,
  localparam int GW          = clog2(N_MACHINES),
  localparam int QCW         = clog2(QUEUE_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  coin_in_i,
  input  logic                  double_wash_req_i,
  input  logic                  sched_en_i,
  input  logic [N_MACHINES-1:0] machine_done_i,
  output logic [N_MACHINES-1:0] machine_coin_o,
  output logic [N_MACHINES-1:0] machine_double_wash_o,
  output logic [N_MACHINES-1:0] busy_mask_o,
  output logic [QCW-1:0]        queue_count_o,
  output logic                  coin_reject_o,
  output logic [CNT_W-1:0]      jobs_done_o
);

  logic                  fifo_head, fifo_full, fifo_empty;
  logic                  dispatch, grant_found, reject_d, reject_q;
  logic [GW-1:0]         grant_idx, last_grant_q, last_grant_d;
  logic [N_MACHINES-1:0] free, rise, grant_oh;
  logic [N_MACHINES-1:0] done_q, busy_q, busy_d, coin_q, dw_q, dw_d;
  logic [CNT_W-1:0]      jobs_q, jobs_d;

  sched_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (coin_in_i),
    .din_i   (double_wash_req_i),
    .pop_i   (dispatch),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (queue_count_o)
  );

  assign free = ~busy_q;
  assign rise = machine_done_i & ~done_q;

  // Round-robin picker: first free machine after the previous grant.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_MACHINES; k++) begin
      idx = (int'(last_grant_q) + k) % N_MACHINES;
      if (!grant_found && free[idx]) begin
        grant_found = 1'b1;
        grant_idx   = GW'(idx);
      end
    end
  end

  assign dispatch = ~fifo_empty & sched_en_i & grant_found;

  always_comb begin
    grant_oh     = '0;
    dw_d         = dw_q;
    last_grant_d = last_grant_q;
    if (dispatch) begin
      grant_oh[grant_idx] = 1'b1;
      dw_d[grant_idx]     = fifo_head;
      last_grant_d        = grant_idx;
    end
  end

  // A granted machine is always free, so a rise and a grant never hit the same bit.
  // Simultaneous completions add only one to the counter.
  assign busy_d   = (busy_q & ~rise) | grant_oh;
  assign jobs_d   = jobs_q + CNT_W'(|(rise & busy_q));
  assign reject_d = coin_in_i & fifo_full & ~dispatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q       <= '0;
      busy_q       <= '0;
      coin_q       <= '0;
      dw_q         <= '0;
      reject_q     <= 1'b0;
      jobs_q       <= '0;
      last_grant_q <= GW'(N_MACHINES - 1);
    end else begin
      done_q       <= machine_done_i;
      busy_q       <= busy_d;
      coin_q       <= grant_oh;
      dw_q         <= dw_d;
      reject_q     <= reject_d;
      jobs_q       <= jobs_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign machine_coin_o        = coin_q;
  assign machine_double_wash_o = dw_q;
  assign busy_mask_o           = busy_q;
  assign coin_reject_o         = reject_q;
  assign jobs_done_o           = jobs_q;

endmodule

// File: tb/tb_laundry_bank_scheduler.sv
// tb/tb_laundry_bank_scheduler.sv - self-checking bench for laundry_bank_scheduler
module tb_laundry_bank_scheduler;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          coin_in_i = 1'b0;
  logic          dw_req_i = 1'b0;
  logic          sched_en_i = 1'b0;
  logic [N-1:0]  machine_done_i = '0;
  logic [N-1:0]  machine_coin_o, machine_double_wash_o, busy_mask_o;
  logic [2:0]    queue_count_o;
  logic          coin_reject_o;
  logic [CW-1:0] jobs_done_o;

  laundry_bank_scheduler #(.N_MACHINES(N), .QUEUE_DEPTH(D), .CNT_W(CW)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .coin_in_i             (coin_in_i),
    .double_wash_req_i     (dw_req_i),
    .sched_en_i            (sched_en_i),
    .machine_done_i        (machine_done_i),
    .machine_coin_o        (machine_coin_o),
    .machine_double_wash_o (machine_double_wash_o),
    .busy_mask_o           (busy_mask_o),
    .queue_count_o         (queue_count_o),
    .coin_reject_o         (coin_reject_o),
    .jobs_done_o           (jobs_done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: request queue, per-machine occupancy and option, last grant.
  bit mq[$];
  bit m_busy[N];
  bit m_dw[N];
  bit m_prev[N];
  int m_lg;
  int m_jobs;
  int exp_coin;
  bit exp_rej;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_dw[i] = 0; m_prev[i] = 0;
    end
    m_lg = N - 1; m_jobs = 0; exp_coin = 0; exp_rej = 0;
  endtask

  task automatic model_edge();
    int  g, idx, pre;
    bit  disp, any;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      idx = (m_lg + k) % N;
      if (g < 0 && !m_busy[idx]) g = idx;
    end
    pre  = mq.size();
    disp = (pre > 0) && sched_en_i && (g >= 0);
    exp_coin = 0;
    exp_rej  = 0;
    if (disp) begin
      m_dw[g]  = mq.pop_front();
      exp_coin = 1 << g;
      m_lg     = g;
    end
    if (coin_in_i) begin
      if (pre < D || disp) mq.push_back(dw_req_i);
      else exp_rej = 1;
    end
    any = 0;
    for (int i = 0; i < N; i++) begin
      if (machine_done_i[i] && !m_prev[i] && m_busy[i]) begin
        m_busy[i] = 0;
        any = 1;
      end
      m_prev[i] = machine_done_i[i];
    end
    if (disp) m_busy[g] = 1;
    if (any) m_jobs = (m_jobs + 1) % (1 << CW);
  endtask

  task automatic compare_all(input string ph);
    int bm, dm;
    bm = 0; dm = 0;
    for (int i = 0; i < N; i++) begin
      bm |= int'(m_busy[i]) << i;
      dm |= int'(m_dw[i]) << i;
    end
    check({ph, ".coin"},   32'(machine_coin_o), exp_coin);
    check({ph, ".busy"},   32'(busy_mask_o), bm);
    check({ph, ".dw"},     32'(machine_double_wash_o), dm);
    check({ph, ".qcount"}, 32'(queue_count_o), mq.size());
    check({ph, ".reject"}, 32'(coin_reject_o), 32'(exp_rej));
    check({ph, ".jobs"},   32'(jobs_done_o), m_jobs);
  endtask

  // Entered and left just after a falling edge.
  task automatic step(input string ph, input bit c, input bit d, input bit e, input logic [N-1:0] dn);
    coin_in_i = c; dw_req_i = d; sched_en_i = e; machine_done_i = dn;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(ph);
    @(negedge clk);
    coin_in_i = 1'b0;
  endtask

  task automatic check_zero(input string ph);
    check({ph, ".z_coin"}, 32'(machine_coin_o), 0);
    check({ph, ".z_busy"}, 32'(busy_mask_o), 0);
    check({ph, ".z_dw"},   32'(machine_double_wash_o), 0);
    check({ph, ".z_q"},    32'(queue_count_o), 0);
    check({ph, ".z_rej"},  32'(coin_reject_o), 0);
    check({ph, ".z_jobs"}, 32'(jobs_done_o), 0);
  endtask

  // Asynchronous reset asserted in the middle of a low clock phase.
  task automatic do_reset(input string ph);
    #2 rst_n = 1'b0;
    #1 check_zero(ph);
    model_reset();
    coin_in_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] dn;
    model_reset();
    #1 check_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Dispatch to an idle bank.
    step("idle0", 1, 1, 1, '0);
    check("idle0.q1", 32'(queue_count_o), 1);
    step("idle1", 0, 0, 1, '0);
    check("idle1.coin", 32'(machine_coin_o), 32'h1);
    check("idle1.dw0", 32'(machine_double_wash_o[0]), 1);
    check("idle1.busy", 32'(busy_mask_o), 32'h1);
    check("idle1.q0", 32'(queue_count_o), 0);
    step("idle2", 0, 0, 1, '0);
    check("idle2.pulse", 32'(machine_coin_o), 0);

    // Round robin and reuse.
    do_reset("rr_rst");
    for (int i = 0; i < 4; i++) step("rr", 1, 0, 1, '0);
    step("rr", 0, 0, 1, '0);
    check("rr.busyall", 32'(busy_mask_o), 32'hF);
    step("rr5", 1, 1, 1, '0);
    step("rr5w", 0, 0, 1, '0);
    check("rr5w.q1", 32'(queue_count_o), 1);
    step("rr_done2", 0, 0, 1, 4'b0100);
    check("rr_done2.busy", 32'(busy_mask_o), 32'hB);
    check("rr_done2.q1", 32'(queue_count_o), 1);
    step("rr_reuse", 0, 0, 1, 4'b0100);
    check("rr_reuse.coin", 32'(machine_coin_o), 32'h4);
    check("rr_reuse.dw2", 32'(machine_double_wash_o[2]), 1);

    // Queue full with every machine busy.
    for (int i = 0; i < 4; i++) step("full", 1, i[0], 1, 4'b0100);
    check("full.q4", 32'(queue_count_o), 4);
    step("full5", 1, 0, 1, 4'b0100);
    check("full5.reject", 32'(coin_reject_o), 1);
    step("full6", 0, 0, 1, 4'b0100);
    check("full6.noreject", 32'(coin_reject_o), 0);
    step("full_done0", 0, 0, 1, 4'b0101);
    step("full_poppush", 1, 1, 1, 4'b0101);
    check("full_poppush.q4", 32'(queue_count_o), 4);
    check("full_poppush.rej", 32'(coin_reject_o), 0);
    check("full_poppush.coin", 32'(machine_coin_o), 32'h1);

    // Held dispatch.
    do_reset("hold_rst");
    step("hold", 1, 0, 0, '0);
    step("hold", 1, 1, 0, '0);
    step("hold", 0, 0, 0, '0);
    check("hold.nocoin", 32'(machine_coin_o), 0);
    check("hold.q2", 32'(queue_count_o), 2);
    step("rel0", 0, 0, 1, '0);
    check("rel0.coin", 32'(machine_coin_o), 32'h1);
    step("rel1", 0, 0, 1, '0);
    check("rel1.coin", 32'(machine_coin_o), 32'h2);

    // Done level held on busy machine 1, then on idle machine 1.
    for (int i = 0; i < 10; i++) step("lvl", 0, 0, 1, 4'b0010);
    check("lvl.jobs1", 32'(jobs_done_o), 1);
    for (int i = 0; i < 3; i++) step("lvl_lo", 0, 0, 1, '0);
    for (int i = 0; i < 10; i++) step("lvl_idle", 0, 0, 1, 4'b0010);
    check("lvl_idle.jobs1", 32'(jobs_done_o), 1);

    // Reset mid-run with a loaded queue and a fully busy bank.
    do_reset("ar_pre");
    for (int i = 0; i < 7; i++) step("ar_fill", 1, 0, 1, '0);
    for (int i = 0; i < 3; i++) step("ar_fill", 0, 0, 1, '0);
    check("ar.busy", 32'(busy_mask_o), 32'hF);
    check("ar.q3", 32'(queue_count_o), 3);
    do_reset("ar");
    step("ar_next", 1, 0, 1, '0);
    step("ar_next", 0, 0, 1, '0);
    check("ar_next.coin", 32'(machine_coin_o), 32'h1);

    // Randomized traffic against the model.
    dn = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) dn[i] = ~dn[i];
      if ($urandom_range(0, 499) == 0) do_reset("rnd_rst");
      else step("rnd", ($urandom_range(0, 2) == 0), 1'($urandom), ($urandom_range(0, 9) != 0), dn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
